// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported memory between the IF fetch port and the MEM load/store port.
// Latency : accept in cycle 0, mem_req_o in cycle 1, rvalid in cycle 2 (immediate gnt/rvalid), IDLE in cycle 3.
// Backpressure: one transaction outstanding; requesters hold req until gnt; memory stalls via mem_gnt_i / mem_rvalid_i.
// Ports: clk/rst (async active-high); flush_i; if_* fetch port; d_* load/store port;
//        mem_* registered memory request side plus mem_gnt_i/mem_rvalid_i/mem_rdata_i; busy_o = not IDLE.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            squash_q, squash_d;
  logic            owner_d_q;          // 1: data port owns the transaction, 0: fetch port
  logic            starve;
  logic            fetch_ok;
  logic            grant_f, grant_d;
  logic            rsp_take;

  // Grants are combinational from the requests; gating with rst keeps the
  // gnt pulses quiet while reset is held even though state is already IDLE.
  assign fetch_ok = if_req_i & ~flush_i;
  assign starve   = (streak_q == SW'(STARVE_LIMIT));
  assign grant_f  = ~rst & (state_q == IDLE) & fetch_ok & (~d_req_i | starve);
  assign grant_d  = ~rst & (state_q == IDLE) & d_req_i & ~grant_f;

  assign if_gnt_o = grant_f;
  assign d_gnt_o  = grant_d;
  assign busy_o   = (state_q != IDLE);

  // Response is routed in the same cycle it arrives. A flush coinciding with
  // the response is also honoured so a wrong-path word never leaks out.
  assign rsp_take    = (state_q == RSP) & mem_rvalid_i;
  assign if_rvalid_o = rsp_take & ~owner_d_q & ~squash_q & ~flush_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign d_rvalid_o  = rsp_take & owner_d_q;
  assign d_rdata_o   = d_rvalid_o ? mem_rdata_i : '0;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    squash_d = squash_q;

    case (state_q)
      IDLE: begin
        if (grant_f) begin
          state_d  = REQ;
          streak_d = '0;
        end else if (grant_d) begin
          state_d = REQ;
          if (if_req_i) begin
            streak_d = starve ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end
      end
      REQ: begin
        // gnt together with rvalid still lands in RSP; the response is
        // only taken from RSP so the same-cycle rvalid is dropped.
        if (mem_gnt_i) state_d = RSP;
      end
      RSP: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && flush_i && !owner_d_q) squash_d = 1'b1;
    if (state_d == IDLE) squash_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      squash_q <= squash_d;
    end
  end

  // Request-side registers: loaded on accept, held through REQ/RSP. Fetches
  // always read a full word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d_q   <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (grant_d) begin
        owner_d_q   <= 1'b1;
        mem_req_o   <= 1'b1;
        mem_we_o    <= d_we_i;
        mem_be_o    <= d_be_i;
        mem_addr_o  <= d_addr_i;
        mem_wdata_o <= d_wdata_i;
      end else if (grant_f) begin
        owner_d_q   <= 1'b0;
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_be_o    <= {BE_W{1'b1}};
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
      end else if ((state_q == REQ) && mem_gnt_i) begin
        mem_req_o <= 1'b0;
      end
    end
  end

endmodule
